// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the 8..11-bit Fibonacci LFSR and its period monitor.
// Sizes are selected by a 2-bit mode: n = 8 + mode.
package lfsr_pkg;

    localparam int unsigned MaxN = 11;
    localparam logic [MaxN-1:0] LfsrSeed = MaxN'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSeed,
        StCount
    } mon_state_t;

    typedef enum logic [2:0] {
        ErrNone    = 3'd0,
        ErrSeed    = 3'd1,
        ErrLockup  = 3'd2,
        ErrRange   = 3'd3,
        ErrTimeout = 3'd4,
        ErrModeChg = 3'd5,
        ErrShort   = 3'd6
    } err_code_t;

    // Maximal sequence length 2^n-1 for the selected size.
    function automatic logic [MaxN:0] exp_period(input logic [1:0] mode);
        unique case (mode)
            2'b00:   return (MaxN+1)'(255);
            2'b01:   return (MaxN+1)'(511);
            2'b10:   return (MaxN+1)'(1023);
            default: return (MaxN+1)'(2047);
        endcase
    endfunction

    // Low n bits set; any LFSR state bit outside this mask is out of range.
    function automatic logic [MaxN-1:0] width_mask(input logic [1:0] mode);
        unique case (mode)
            2'b00:   return MaxN'(11'h0ff);
            2'b01:   return MaxN'(11'h1ff);
            2'b10:   return MaxN'(11'h3ff);
            default: return MaxN'(11'h7ff);
        endcase
    endfunction

endpackage

// File: rtl/lfsr_period_monitor.sv
// Measures the LFSR period from seed back to seed and compares it with 2^n-1,
// reporting pass/fail with an error code and the number of counted steps.
module lfsr_period_monitor
    import lfsr_pkg::*;
#(
    parameter int unsigned MAX_N = 11,
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [MAX_N-1:0] lfsr_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] period
);

    mon_state_t       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    err_code_t        err_q, err_d;
    logic [CNT_W-1:0] period_q, period_d;

    logic [MAX_N-1:0] mask_w;
    logic [MAX_N-1:0] seed_w;
    logic [CNT_W-1:0] exp_w;
    logic             end_run;
    err_code_t        end_err;

    assign mask_w = MAX_N'(width_mask(mode_q));
    assign seed_w = MAX_N'(LfsrSeed);
    assign exp_w  = CNT_W'(exp_period(mode_q));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        period_d = period_q;
        end_run  = 1'b0;
        end_err  = ErrNone;

        if (start && !stop) begin
            // Accepted in any state; an in-flight run is abandoned without a done pulse.
            state_d = StSeed;
            mode_d  = mode;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StSeed: begin
                    if (mode != mode_q) begin
                        end_run = 1'b1;
                        end_err = ErrModeChg;
                    end else if (lfsr_in != seed_w) begin
                        end_run = 1'b1;
                        end_err = ErrSeed;
                    end else if (!stop) begin
                        state_d = StCount;
                        cnt_d   = CNT_W'(1);
                    end
                end
                StCount: begin
                    if (mode != mode_q) begin
                        end_run = 1'b1;
                        end_err = ErrModeChg;
                    end else if ((lfsr_in & ~mask_w) != '0) begin
                        end_run = 1'b1;
                        end_err = ErrRange;
                    end else if (lfsr_in == '0) begin
                        end_run = 1'b1;
                        end_err = ErrLockup;
                    end else if (lfsr_in == seed_w) begin
                        end_run = 1'b1;
                        end_err = (cnt_q == exp_w) ? ErrNone : ErrShort;
                    end else if (cnt_q == exp_w) begin
                        end_run = 1'b1;
                        end_err = ErrTimeout;
                    end else if (!stop) begin
                        // Paused cycles are not counted.
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase

            if (end_run) begin
                state_d  = StIdle;
                done_d   = 1'b1;
                pass_d   = (end_err == ErrNone);
                err_d    = end_err;
                period_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mode_q   <= 2'b00;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= ErrNone;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            period_q <= period_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_code = err_q;
    assign period   = period_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed bench for lfsr_period_monitor: a behavioural Fibonacci LFSR drives lfsr_in,
// with forced values injected to provoke each error code.
module tb_lfsr_period_monitor;

    localparam int unsigned MAX_N = 11;
    localparam int unsigned CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [MAX_N-1:0] lfsr_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] period;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned done_seen = 0;

    logic [MAX_N-1:0] lfsr_s;
    logic             force_en;
    logic [MAX_N-1:0] force_val;

    lfsr_period_monitor #(
        .MAX_N(MAX_N),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .lfsr_in  (lfsr_in),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_code (err_code),
        .period   (period)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Maximal-length taps: 8:{8,6,5,4} 9:{9,5} 10:{10,7} 11:{11,9}
    function automatic logic [MAX_N-1:0] lfsr_next(input logic [MAX_N-1:0] s, input logic [1:0] m);
        logic        fb;
        logic [11:0] msk;
        case (m)
            2'b00:   fb = s[7] ^ s[5] ^ s[4] ^ s[3];
            2'b01:   fb = s[8] ^ s[4];
            2'b10:   fb = s[9] ^ s[6];
            default: fb = s[10] ^ s[8];
        endcase
        msk = (12'd1 << (8 + int'(m))) - 12'd1;
        return {s[9:0], fb} & msk[MAX_N-1:0];
    endfunction

    // One clock edge; the model LFSR reacts to the controls present at that edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (start && !stop) lfsr_s = MAX_N'(1);
        else if (!stop) lfsr_s = lfsr_next(lfsr_s, mode);
        lfsr_in = force_en ? force_val : lfsr_s;
        if (done) done_seen++;
    endtask

    task automatic force_in(input logic [MAX_N-1:0] v);
        force_en  = 1'b1;
        force_val = v;
        lfsr_in   = v;
    endtask

    task automatic start_run(input logic [1:0] m);
        force_en = 1'b0;
        mode     = m;
        stop     = 1'b0;
        start    = 1'b1;
        cycle();
        start    = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!done && n < budget);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int n;
    int paused;
    int unsigned d0;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 2'b00;
        lfsr_s    = MAX_N'(1);
        lfsr_in   = MAX_N'(1);
        force_en  = 1'b0;
        force_val = '0;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_code, 0);
        check("rst_period", period, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_n(2);

        // Mode 00, real sequence: done visible after edge k+256.
        start_run(2'b00);
        check("m0_busy", busy, 1);
        run_until_done(400, n);
        check("m0_latency", n, 256);
        check("m0_done", done, 1);
        check("m0_period", period, 255);
        check("m0_pass", pass, 1);
        check("m0_err", err_code, 0);
        check("m0_busy_low", busy, 0);
        cycle();
        check("m0_done_pulse", done, 0);
        check("m0_period_hold", period, 255);

        // Mode 11 with stop high 10 of every 500 edges: 40 paused edges add to latency.
        start_run(2'b11);
        paused = 0;
        n = 0;
        do begin
            stop = (((n + 1) % 500) >= 490);
            if (stop) paused++;
            cycle();
            n++;
        end while (!done && n < 3000);
        stop = 1'b0;
        check("m3_done", done, 1);
        check("m3_latency", n, 2088);
        check("m3_period", period, 2047);
        check("m3_pass", pass, 1);

        // Mode 01, lockup seen while cnt=40.
        start_run(2'b01);
        run_n(40);
        force_in('0);
        cycle();
        check("lock_done", done, 1);
        check("lock_err", err_code, 2);
        check("lock_period", period, 40);
        check("lock_pass", pass, 0);

        // Mode 00, out-of-range bit 8 at cnt=20.
        start_run(2'b00);
        run_n(20);
        force_in(11'h101);
        cycle();
        check("range_done", done, 1);
        check("range_err", err_code, 3);
        check("range_period", period, 20);

        // Early return to seed at cnt=100.
        start_run(2'b00);
        run_n(100);
        force_in(11'h001);
        cycle();
        check("short_done", done, 1);
        check("short_err", err_code, 6);
        check("short_period", period, 100);
        check("short_pass", pass, 0);

        // Stub stuck at 2 after the first step: times out at cnt=255.
        start_run(2'b00);
        cycle();
        force_in(11'h002);
        run_until_done(400, n);
        check("tmo_latency", n + 1, 256);
        check("tmo_err", err_code, 4);
        check("tmo_period", period, 255);

        // Mode 10, mode changed to 01 at cnt=50.
        start_run(2'b10);
        run_n(50);
        mode = 2'b01;
        cycle();
        check("mchg_done", done, 1);
        check("mchg_err", err_code, 5);
        check("mchg_period", period, 50);

        // Seed mismatch while in SEED.
        start_run(2'b00);
        force_in(11'h005);
        cycle();
        check("seed_done", done, 1);
        check("seed_err", err_code, 1);
        check("seed_period", period, 0);

        // Restart at cnt=300: only the second run produces done.
        d0 = done_seen;
        start_run(2'b10);
        run_n(300);
        check("rs_busy", busy, 1);
        start_run(2'b10);
        run_until_done(1200, n);
        check("rs_latency", n, 1024);
        check("rs_period", period, 1023);
        check("rs_pass", pass, 1);
        check("rs_done_count", done_seen - d0, 1);

        // start && stop is ignored.
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", busy, 0);
        cycle();
        check("ss_busy2", busy, 0);
        check("ss_period", period, 1023);

        // Asynchronous reset mid-COUNT.
        start_run(2'b00);
        run_n(30);
        d0 = done_seen;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_pass", pass, 0);
        check("mrst_period", period, 0);
        check("mrst_err", err_code, 0);
        run_n(2);
        @(negedge clk);
        rst_n = 1'b1;
        run_n(300);
        check("mrst_no_done", done_seen - d0, 0);
        check("mrst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
